centroid_divider: RTL and testbench
===================================

# centroid_divider

Sequential divider stage that sits directly downstream of the colour-detect accumulator. Once per frame, on a start pulse, it captures the accumulated x/y pixel sums and the matched-pixel count. It computes the rounded centroid with one shared restoring divider, so no combinational divide is needed. It then presents the packed coordinate with a one-cycle valid pulse and a found flag to the coordinate consumer (AXI register bank / overlay).

## Interface
Parameters:
- SUM_W, 32, width of x_sum / y_sum inputs
- CNT_W, 20, width of the count input
- COORD_W, 16, width of each output coordinate field

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; sums/count valid this cycle (end of frame)
- x_sum  in  SUM_W  accumulated x of matched pixels
- y_sum  in  SUM_W  accumulated y of matched pixels
- count  in  CNT_W  number of matched pixels
- busy  out  1  division in progress; start ignored while high
- coord  out  2*COORD_W  {x_centroid, y_centroid}; x in upper half
- coord_valid  out  1  one-cycle pulse when coord/found updated
- found  out  1  1 = last result had count≠0

## Operation
- States: IDLE, DIV_X, DIV_Y, DONE.
- IDLE: when start=1 and count≠0, latch x_sum, y_sum and count, load divider with x numerator, and go to DIV_X.
- IDLE with start=1 and count=0: go to DONE directly. coord is held unchanged; found is cleared to 0.
- Numerator = sum + (count >> 1), computed at SUM_W+1 bits, so it never overflows. Denominator = count, zero-extended.
- This gives round-half-up: 7/2 → 4 and 5/4 → 1.
- DIV_X: the divider produces 1 quotient bit per cycle over N = SUM_W+1 cycles. On completion, store the x quotient, load the y numerator, and go to DIV_Y.
- DIV_Y: same N cycles. On completion, go to DONE.
- DONE: lasts one cycle.
  - Register coord = {sat(qx), sat(qy)} and set found=1.
  - Pulse coord_valid, then return to IDLE.
- sat(q): if q ≥ 2^COORD_W, the field is all ones; otherwise q[COORD_W-1:0].
- start while busy=1: ignored. The input frame is dropped, with no queueing.
- Remainders are discarded.

## Timing
- Reset values: busy=0, coord_valid=0, found=0, coord=0; state=IDLE.
- Let T be the cycle in which start is sampled high.
- count≠0 path:
  - busy=1 in cycles T+1 … T+2N.
  - X division occupies T+1 … T+N; Y division occupies T+N+1 … T+2N.
  - coord, found and coord_valid are updated at T+2N+1, with busy=0 in that cycle. With defaults, N=33 and valid is at T+67.
- count=0 path: coord_valid=1 and found=0 at T+1. busy is never high.
- Back-to-back: a start sampled in the coord_valid cycle (busy=0) is accepted.
- Reset asserted mid-division:
  - All state returns to IDLE on the next edge.
  - No coord_valid is produced for the aborted frame.
  - Outputs take their reset values.
- coord and found hold between pulses. Consumers sample them only on coord_valid.
- Inputs need only be stable in cycle T; they are not sampled afterwards.

## Structure
- Package centroid_pkg:
  - SUM_W/CNT_W/COORD_W defaults
  - state enum {IDLE, DIV_X, DIV_Y, DONE}
  - saturation helper function
- Sub-module seq_divider, a restoring divider with one bit per cycle.
  - Ports: clk, reset_n, load, numerator[SUM_W:0], denominator[CNT_W-1:0], quotient[SUM_W:0], done.
  - done is a pulse N cycles after load. It is instantiated once and reused for x and y.
- The top level holds the FSM, the latched y numerator and count, the x quotient register, and the output registers.

## Test plan
- start, x_sum=6400, y_sum=3600, count=10 → at T+67: coord=0x0280_0168 (640, 360), found=1, coord_valid for exactly 1 cycle; busy high T+1…T+66.
- Rounding: x_sum=7, y_sum=5, count=2 → x=4 (3.5→4), y=3 (2.5→3). Then x_sum=5, y_sum=6, count=4 → x=1 (1.25→1), y=2 (1.5→2).
- count=0 after a prior result of 0x0280_0168 → at T+1: coord_valid=1, found=0, coord still 0x0280_0168; busy never high.
- Second start at T+10 with different sums → ignored, only one coord_valid (T+67) with the first frame's values. A start at T+67 is accepted and its result is valid at T+134.
- reset_n low at T+20 for one cycle → busy=0, coord=0, found=0 from T+21; no coord_valid for 200 cycles afterwards.
- Saturation: x_sum=0xFFFF_FFFF, y_sum=100, count=1 → coord=0xFFFF_0064, found=1.

Source files
------------

// File: rtl/centroid_pkg.sv
// Shared widths, FSM state encoding and output saturation for the centroid divider.
// Pure declarations; no logic, no latency.
package centroid_pkg;

  localparam int DEF_SUM_W   = 32;
  localparam int DEF_CNT_W   = 20;
  localparam int DEF_COORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    DONE
  } state_e;

  // Clamp a full-width quotient into one coordinate field.
  function automatic logic [DEF_COORD_W-1:0] sat(input logic [DEF_SUM_W:0] q);
    if (|q[DEF_SUM_W:DEF_COORD_W]) sat = '1;
    else                           sat = q[DEF_COORD_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses SUM_W+1 cycles after load.
// No backpressure: a new load restarts the division immediately.
module seq_divider
  import centroid_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SUM_W:0]   numerator,
  input  logic [CNT_W-1:0] denominator,
  output logic [SUM_W:0]   quotient,
  output logic             done
);

  localparam int N  = SUM_W + 1;
  localparam int CW = $clog2(N + 1);

  logic [SUM_W:0]   quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] den_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W:0]   trial;
  logic             fits;

  // quo_q doubles as the numerator shift register: dividend bits leave the top
  // while quotient bits enter the bottom.
  always_comb begin
    trial = {rem_q, quo_q[SUM_W]};
    fits  = (trial >= {1'b0, den_q});
    rem_d = fits ? CNT_W'(trial - {1'b0, den_q}) : trial[CNT_W-1:0];
    quo_d = {quo_q[SUM_W-1:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= numerator;
      rem_q <= '0;
      den_q <= denominator;
      cnt_q <= CW'(N);
    end else if (cnt_q != '0) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // The final bit is presented combinationally so the caller can reload in the same cycle.
  assign done     = (cnt_q == CW'(1));
  assign quotient = quo_d;

endmodule

// File: rtl/centroid_divider.sv
// Per-frame rounded centroid (sum/count) for x then y through one shared divider; result 2*(SUM_W+1)+1 cycles after start.
// start is dropped while busy; coord/found hold between one-cycle coord_valid pulses.
module centroid_divider
  import centroid_pkg::*;
#(
  parameter int SUM_W   = DEF_SUM_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [SUM_W-1:0]     x_sum,
  input  logic [SUM_W-1:0]     y_sum,
  input  logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic [2*COORD_W-1:0] coord,
  output logic                 coord_valid,
  output logic                 found
);

  state_e               state_q, state_d;
  logic [SUM_W:0]       ynum_q, ynum_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SUM_W:0]       qx_q, qx_d;
  logic [2*COORD_W-1:0] coord_q, coord_d;
  logic                 found_q, found_d;
  logic                 valid_q, valid_d;

  logic                 div_load, div_done;
  logic [SUM_W:0]       div_num, div_q;
  logic [CNT_W-1:0]     div_den;
  logic [SUM_W:0]       x_num, y_num;

  // Adding count/2 before the divide gives round-half-up; the extra bit absorbs the carry.
  assign x_num = {1'b0, x_sum} + (SUM_W+1)'(count >> 1);
  assign y_num = {1'b0, y_sum} + (SUM_W+1)'(count >> 1);

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (div_load),
    .numerator   (div_num),
    .denominator (div_den),
    .quotient    (div_q),
    .done        (div_done)
  );

  always_comb begin
    state_d  = state_q;
    ynum_d   = ynum_q;
    count_d  = count_q;
    qx_d     = qx_q;
    coord_d  = coord_q;
    found_d  = found_q;
    valid_d  = 1'b0;
    div_load = 1'b0;
    div_num  = x_num;
    div_den  = count;
    case (state_q)
      // DONE accepts a new frame exactly like IDLE so back-to-back frames lose no cycle.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (count != '0) begin
            div_load = 1'b1;
            ynum_d   = y_num;
            count_d  = count;
            state_d  = DIV_X;
          end else begin
            found_d = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          qx_d     = div_q;
          div_load = 1'b1;
          div_num  = ynum_q;
          div_den  = count_q;
          state_d  = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          coord_d = {sat(qx_q), sat(div_q)};
          found_d = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ynum_q  <= '0;
      count_q <= '0;
      qx_q    <= '0;
      coord_q <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ynum_q  <= ynum_d;
      count_q <= count_d;
      qx_q    <= qx_d;
      coord_q <= coord_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  assign busy        = (state_q == DIV_X) || (state_q == DIV_Y);
  assign coord       = coord_q;
  assign found       = found_q;
  assign coord_valid = valid_q;

endmodule

// File: tb/tb_centroid_divider.sv
// Directed checks of centroid_divider: latency, rounding, zero count, saturation,
// dropped start while busy, back-to-back frames and reset mid-division.
module tb_centroid_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_sum = '0;
  logic [31:0] y_sum = '0;
  logic [19:0] count = '0;
  logic        busy;
  logic [31:0] coord;
  logic        coord_valid;
  logic        found;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_n;
  int busy_n;
  int pulses;

  centroid_divider dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .x_sum       (x_sum),
    .y_sum       (y_sum),
    .count       (count),
    .busy        (busy),
    .coord       (coord),
    .coord_valid (coord_valid),
    .found       (found)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle (cycle T), then scrambles the inputs; returns in cycle T+1.
  task automatic pulse_start(input logic [31:0] xs, input logic [31:0] ys, input logic [19:0] c);
    x_sum = xs;
    y_sum = ys;
    count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    x_sum = $urandom;
    y_sum = $urandom;
    count = 20'($urandom);
  endtask

  // Cycles spent before coord_valid is seen (0 = valid now), plus busy cycles on the way.
  task automatic wait_valid(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (coord_valid !== 1'b1 && n < 300) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", coord_valid, 0);
    check("rst_found", found, 0);
    check("rst_coord", coord, 32'h0);
    reset_n = 1'b1;
    tick();

    // 6400/10, 3600/10
    pulse_start(32'd6400, 32'd3600, 20'd10);
    check("busy_T1", busy, 1);
    wait_valid(wait_n, busy_n);
    check("lat_640_360", 1 + wait_n, 67);
    check("busy_cycles", busy_n, 66);
    check("coord_640_360", coord, 32'h0280_0168);
    check("found_640_360", found, 1);
    check("busy_at_valid", busy, 0);
    tick();
    check("valid_one_cycle", coord_valid, 0);
    check("coord_hold", coord, 32'h0280_0168);

    // count = 0: immediate not-found result, coord untouched
    pulse_start(32'd1234, 32'd5678, 20'd0);
    check("zero_valid_T1", coord_valid, 1);
    check("zero_found", found, 0);
    check("zero_coord_held", coord, 32'h0280_0168);
    check("zero_busy", busy, 0);
    tick();
    check("zero_valid_drop", coord_valid, 0);
    check("zero_busy_after", busy, 0);

    // rounding: 3.5->4, 2.5->3
    pulse_start(32'd7, 32'd5, 20'd2);
    wait_valid(wait_n, busy_n);
    check("lat_round_a", 1 + wait_n, 67);
    check("coord_round_a", coord, 32'h0004_0003);
    check("found_round_a", found, 1);
    tick();

    // rounding: 1.25->1, 1.5->2
    pulse_start(32'd5, 32'd6, 20'd4);
    wait_valid(wait_n, busy_n);
    check("lat_round_b", 1 + wait_n, 67);
    check("coord_round_b", coord, 32'h0001_0002);
    tick();

    // saturation of x field
    pulse_start(32'hFFFF_FFFF, 32'd100, 20'd1);
    wait_valid(wait_n, busy_n);
    check("lat_sat", 1 + wait_n, 67);
    check("coord_sat", coord, 32'hFFFF_0064);
    check("found_sat", found, 1);
    tick();

    // second start at T+10 is dropped
    pulse_start(32'd6400, 32'd3600, 20'd10);
    repeat (9) tick();
    pulse_start(32'd100, 32'd200, 20'd10);
    wait_valid(wait_n, busy_n);
    check("lat_ignore", 11 + wait_n, 67);
    check("coord_ignore", coord, 32'h0280_0168);

    // start in the coord_valid cycle is accepted
    pulse_start(32'd7, 32'd5, 20'd2);
    check("b2b_busy", busy, 1);
    wait_valid(wait_n, busy_n);
    check("lat_b2b", 68 + wait_n, 134);
    check("coord_b2b", coord, 32'h0004_0003);
    tick();

    // reset for one cycle at T+20 aborts the frame
    pulse_start(32'd6400, 32'd3600, 20'd10);
    repeat (19) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_coord", coord, 32'h0);
    check("abort_found", found, 0);
    check("abort_valid", coord_valid, 0);
    pulses = 0;
    repeat (200) begin
      if (coord_valid === 1'b1) pulses++;
      tick();
    end
    check("abort_no_valid", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
